// File: rtl/latchup_recovery_ctrl.sv
// ============================================================================
//  Module      : latchup_recovery_ctrl
//  Description : Recovery sequencer for one protected supply rail. It qualifies
//                the latched alarm, cycles power, clears the hold-error FF and
//                escalates repeated trips to an acknowledge-only lockout.
//                Optional build macro: LATCHUP_EVENT_LOG_EN (event counter and
//                last-cause ports).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module latchup_recovery_ctrl #(
    parameter int DEBOUNCE      = 4,
    parameter int OFF_CYCLES    = 1000,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 500,
    parameter int QUIET_CYCLES  = 100000,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               la_in,
    input  logic                               test_trip,
    input  logic                               ack,
    output logic                               pwr_en,
    output logic                               clr_out,
    output logic                               busy,
    output logic                               lockout,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`ifdef LATCHUP_EVENT_LOG_EN
    ,
    output logic [15:0]                        event_cnt,
    output logic [1:0]                         last_cause
`endif
);

    localparam int c_TMR_MAX =
        (OFF_CYCLES > CLR_CYCLES)
            ? ((OFF_CYCLES > SETTLE_CYCLES) ? OFF_CYCLES : SETTLE_CYCLES)
            : ((CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES);
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam int c_DEB_W   = $clog2(DEBOUNCE + 1);
    localparam int c_QUIET_W = $clog2(QUIET_CYCLES + 1);
    localparam int c_RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [c_TMR_W-1:0]   c_OFF_LAST    = c_TMR_W'(OFF_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]   c_CLR_LAST    = c_TMR_W'(CLR_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]   c_SETTLE_LAST = c_TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]   c_TMR_SAT     = '1;
    localparam logic [c_DEB_W-1:0]   c_DEB_LAST    = c_DEB_W'(DEBOUNCE - 1);
    localparam logic [c_QUIET_W-1:0] c_QUIET_LAST  = c_QUIET_W'(QUIET_CYCLES - 1);
    localparam logic [c_QUIET_W-1:0] c_QUIET_MAX   = c_QUIET_W'(QUIET_CYCLES);
    localparam logic [c_RTY_W-1:0]   c_RETRY_MAX   = c_RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PWR_OFF = 3'd1,
        S_CLEAR   = 3'd2,
        S_SETTLE  = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_nxt_state;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_DEB_W-1:0]   r_deb;
    logic [c_QUIET_W-1:0] r_quiet;

    logic w_qualified;
    logic w_retry_inc;
    logic w_retry_clr;
    logic w_idle_stay;
    logic w_quiet_hit;

    always_comb begin
        w_nxt_state = r_state;
        w_qualified = la_in && (r_deb == c_DEB_LAST);
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                // test_trip outranks a simultaneously qualified alarm
                if (test_trip) begin
                    w_nxt_state = S_PWR_OFF;
                end else if (w_qualified) begin
                    if (retry_cnt == c_RETRY_MAX) begin
                        w_nxt_state = S_LOCKOUT;
                    end else begin
                        w_nxt_state = S_PWR_OFF;
                        w_retry_inc = 1'b1;
                    end
                end
            end
            S_PWR_OFF: begin
                if (r_timer == c_OFF_LAST) w_nxt_state = S_CLEAR;
            end
            S_CLEAR: begin
                if (r_timer == c_CLR_LAST) w_nxt_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_timer == c_SETTLE_LAST) w_nxt_state = S_IDLE;
            end
            S_LOCKOUT: begin
                if (ack) begin
                    w_nxt_state = S_CLEAR;
                    w_retry_clr = 1'b1;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
        w_idle_stay = (r_state == S_IDLE) && (w_nxt_state == S_IDLE);
        w_quiet_hit = w_idle_stay && !la_in && (r_quiet == c_QUIET_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_deb     <= '0;
            r_quiet   <= '0;
            retry_cnt <= '0;
            pwr_en    <= 1'b1;
            clr_out   <= 1'b0;
            busy      <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;

            // Timer restarts on every state change and parks at all-ones in LOCKOUT
            if (w_nxt_state != r_state) begin
                r_timer <= '0;
            end else if (r_timer != c_TMR_SAT) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_idle_stay && la_in) begin
                r_deb <= r_deb + 1'b1;
            end else begin
                r_deb <= '0;
            end

            if (w_idle_stay && !la_in) begin
                if (r_quiet != c_QUIET_MAX) r_quiet <= r_quiet + 1'b1;
            end else begin
                r_quiet <= '0;
            end

            if (w_retry_clr || w_quiet_hit) begin
                retry_cnt <= '0;
            end else if (w_retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end

            pwr_en  <= !((w_nxt_state == S_PWR_OFF) || (w_nxt_state == S_CLEAR) ||
                         (w_nxt_state == S_LOCKOUT));
            clr_out <= (w_nxt_state == S_CLEAR);
            busy    <= (w_nxt_state != S_IDLE);
            lockout <= (w_nxt_state == S_LOCKOUT);
        end
    end

`ifdef LATCHUP_EVENT_LOG_EN
    // PWR_OFF and LOCKOUT are only ever entered from IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            event_cnt  <= '0;
            last_cause <= 2'b00;
        end else if ((r_state == S_IDLE) && (w_nxt_state != S_IDLE)) begin
            if (event_cnt != 16'hFFFF) event_cnt <= event_cnt + 16'd1;
            if (test_trip) begin
                last_cause <= 2'b10;
            end else if (w_nxt_state == S_LOCKOUT) begin
                last_cause <= 2'b11;
            end else begin
                last_cause <= 2'b01;
            end
        end
    end
`endif

endmodule

`default_nettype wire
